// File: rtl/sim_run_ctrl_if.sv
// Bench-facing bundle for the run controller: start/pc/data-write bus in, run results out.
// Master is the bench side; slave is the controller.
interface sim_run_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 32
);
    logic          start;
    logic [AW-1:0] pc;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          core_rst_n;
    logic          done;
    logic          pass;
    logic [1:0]    status;
    logic [DW-1:0] exit_code;
    logic [CW-1:0] cycles;

    modport master (
        output start, pc, dmem_we, dmem_addr, dmem_wdata,
        input  core_rst_n, done, pass, status, exit_code, cycles
    );

    modport slave (
        input  start, pc, dmem_we, dmem_addr, dmem_wdata,
        output core_rst_n, done, pass, status, exit_code, cycles
    );
endinterface

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: sequences core reset, counts run cycles, ends on TOHOST store or timeout.
// Optional PC_HANG_DETECT_EN adds a stuck-pc detector that ends the run with exit_code all-ones.
module sim_run_ctrl #(
    parameter int              AW          = 32,
    parameter int              DW          = 32,
    parameter int              CW          = 32,
    parameter int              RST_CYCLES  = 1,
    parameter int              MAX_CYCLES  = 200,
    parameter logic [AW-1:0]   TOHOST_ADDR = 'h100,
    parameter int              HANG_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst,
    sim_run_ctrl_if.slave  bus
);
    localparam int            RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    state_t        state_q;
    logic [RW-1:0] rst_cnt_q;
    logic          core_rst_n_q;
    logic          done_q;
    logic          pass_q;
    logic [1:0]    status_q;
    logic [DW-1:0] exit_code_q;
    logic [CW-1:0] cycles_q;

    logic hit;
    logic timeout;
    logic hang;

    assign hit     = bus.dmem_we && (bus.dmem_addr == TOHOST_ADDR);
    assign timeout = (cycles_q == LAST_CYC);

`ifdef PC_HANG_DETECT_EN
    localparam int HW = $clog2(HANG_CYCLES + 1);

    logic [AW-1:0] pc_prev_q;
    logic [HW-1:0] hang_cnt_q;
    logic          pc_same;

    // The first RUN cycle has no meaningful previous pc, so it never counts as unchanged.
    assign pc_same = (state_q == S_RUN) && (cycles_q != '0) && (bus.pc == pc_prev_q);
    assign hang    = pc_same && (hang_cnt_q == HW'(HANG_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_prev_q  <= '0;
            hang_cnt_q <= '0;
        end else begin
            pc_prev_q  <= bus.pc;
            hang_cnt_q <= pc_same ? hang_cnt_q + 1'b1 : '0;
        end
    end
`else
    logic unused_pc;

    assign hang      = 1'b0;
    assign unused_pc = ^bus.pc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            status_q     <= 2'b00;
            exit_code_q  <= '0;
            cycles_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q      <= S_RESET;
                        rst_cnt_q    <= RW'(RST_CYCLES);
                        core_rst_n_q <= 1'b0;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        status_q     <= 2'b00;
                        exit_code_q  <= '0;
                        cycles_q     <= '0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt_q == RW'(1)) begin
                        state_q      <= S_RUN;
                        core_rst_n_q <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - 1'b1;
                    end
                end
                S_RUN: begin
                    // Exit edges leave cycles untouched so DONE reports the cycle that ended the run.
                    if (hit) begin
                        state_q      <= S_DONE;
                        core_rst_n_q <= 1'b0;
                        done_q       <= 1'b1;
                        exit_code_q  <= bus.dmem_wdata;
                        pass_q       <= (bus.dmem_wdata == DW'(1));
                        status_q     <= (bus.dmem_wdata == DW'(1)) ? 2'b01 : 2'b10;
                    end else if (hang) begin
                        state_q      <= S_DONE;
                        core_rst_n_q <= 1'b0;
                        done_q       <= 1'b1;
                        exit_code_q  <= '1;
                        pass_q       <= 1'b0;
                        status_q     <= 2'b10;
                    end else if (timeout) begin
                        state_q      <= S_DONE;
                        core_rst_n_q <= 1'b0;
                        done_q       <= 1'b1;
                        exit_code_q  <= '0;
                        pass_q       <= 1'b0;
                        status_q     <= 2'b11;
                    end else begin
                        cycles_q <= cycles_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.core_rst_n = core_rst_n_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.status     = status_q;
    assign bus.exit_code  = exit_code_q;
    assign bus.cycles     = cycles_q;
endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: per-run stimulus plans scored against an outcome model of the run rules.
module tb_sim_run_ctrl;
    localparam int            AW     = 32;
    localparam int            DW     = 32;
    localparam int            CW     = 32;
    localparam int            RSTC   = 3;
    localparam int            MAXC   = 200;
    localparam int            HANGC  = 16;
    localparam logic [AW-1:0] TOHOST = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sim_run_ctrl_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

    sim_run_ctrl #(
        .AW(AW), .DW(DW), .CW(CW), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC),
        .TOHOST_ADDR(TOHOST), .HANG_CYCLES(HANGC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Per-run-cycle stimulus plan, indexed by the value cycles shows in that RUN cycle.
    logic          pl_we   [MAXC];
    logic [AW-1:0] pl_addr [MAXC];
    logic [DW-1:0] pl_wd   [MAXC];
    logic [AW-1:0] pl_pc   [MAXC];

    task automatic clear_plan();
        for (int k = 0; k < MAXC; k++) begin
            pl_we[k]   = 1'b0;
            pl_addr[k] = $urandom;
            pl_wd[k]   = $urandom;
            pl_pc[k]   = AW'(k * 4);
        end
    endtask

    // Outcome of a run: first cycle where a mailbox store, a hang or the timeout ends it.
    task automatic predict(output int e_cyc, output logic [1:0] e_st, output logic [DW-1:0] e_exit);
        int streak;
        streak = 0;
        e_cyc  = MAXC - 1;
        e_st   = 2'b11;
        e_exit = '0;
        for (int k = 0; k < MAXC; k++) begin
            if (k > 0 && pl_pc[k] == pl_pc[k-1]) streak++;
            else streak = 0;
            if (pl_we[k] && pl_addr[k] == TOHOST) begin
                e_cyc  = k;
                e_exit = pl_wd[k];
                e_st   = (pl_wd[k] == 1) ? 2'b01 : 2'b10;
                return;
            end
`ifdef PC_HANG_DETECT_EN
            if (streak >= HANGC) begin
                e_cyc  = k;
                e_st   = 2'b10;
                e_exit = '1;
                return;
            end
`endif
        end
    endtask

    task automatic run_plan(input string name);
        int            e_cyc;
        logic [1:0]    e_st;
        logic [DW-1:0] e_exit;
        predict(e_cyc, e_st, e_exit);
        bus.start   = 1'b1;
        bus.dmem_we = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        total++;
        if ({bus.done, bus.pass, bus.status, bus.exit_code, bus.cycles} !== '0) begin
            bad++;
            $display("FAIL %s clear-on-start got=%h want=0", name,
                     {bus.done, bus.pass, bus.status, bus.exit_code, bus.cycles});
        end
        // Mailbox stores and start pulses during core reset must be ignored.
        for (int i = 0; i < RSTC; i++) begin
            total++;
            if (bus.core_rst_n !== 1'b0) begin
                bad++;
                $display("FAIL %s reset-phase i=%0d core_rst_n got=%b want=0", name, i, bus.core_rst_n);
            end
            bus.start      = 1'($urandom_range(0, 1));
            bus.dmem_we    = 1'b1;
            bus.dmem_addr  = TOHOST;
            bus.dmem_wdata = 1;
            bus.pc         = $urandom;
            @(posedge clk); #1;
        end
        for (int k = 0; k <= e_cyc; k++) begin
            total++;
            if ({bus.core_rst_n, bus.done, bus.status, bus.cycles} !== {1'b1, 1'b0, 2'b00, CW'(k)}) begin
                bad++;
                $display("FAIL %s run k=%0d {rstn,done,status,cycles} got=%h want=%h", name, k,
                         {bus.core_rst_n, bus.done, bus.status, bus.cycles},
                         {1'b1, 1'b0, 2'b00, CW'(k)});
            end
            bus.start      = 1'($urandom_range(0, 1));
            bus.dmem_we    = pl_we[k];
            bus.dmem_addr  = pl_addr[k];
            bus.dmem_wdata = pl_wd[k];
            bus.pc         = pl_pc[k];
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        for (int h = 0; h < 3; h++) begin
            total++;
            if ({bus.core_rst_n, bus.done, bus.pass, bus.status, bus.exit_code, bus.cycles} !==
                {1'b0, 1'b1, (e_st == 2'b01), e_st, e_exit, CW'(e_cyc)}) begin
                bad++;
                $display("FAIL %s done h=%0d {rstn,done,pass,status,exit,cycles} got=%h want=%h", name, h,
                         {bus.core_rst_n, bus.done, bus.pass, bus.status, bus.exit_code, bus.cycles},
                         {1'b0, 1'b1, (e_st == 2'b01), e_st, e_exit, CW'(e_cyc)});
            end
            bus.dmem_we    = 1'($urandom_range(0, 1));
            bus.dmem_addr  = TOHOST;
            bus.dmem_wdata = $urandom;
            bus.pc         = $urandom;
            @(posedge clk); #1;
        end
        bus.dmem_we = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.dmem_we = 1'b0; bus.dmem_addr = '0; bus.dmem_wdata = '0; bus.pc = '0;
        rst = 1'b1;
        #3;
        total++;
        if ({bus.core_rst_n, bus.done, bus.pass, bus.status, bus.exit_code, bus.cycles} !== '0) begin
            bad++;
            $display("FAIL reset-asserted got=%h want=0",
                     {bus.core_rst_n, bus.done, bus.pass, bus.status, bus.exit_code, bus.cycles});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.dmem_we = 1'b1; bus.dmem_addr = TOHOST; bus.dmem_wdata = 1;
            @(posedge clk); #1;
            total++;
            if ({bus.core_rst_n, bus.done, bus.pass, bus.status, bus.exit_code, bus.cycles} !== '0) begin
                bad++;
                $display("FAIL idle-no-start i=%0d got=%h want=0", i,
                         {bus.core_rst_n, bus.done, bus.pass, bus.status, bus.exit_code, bus.cycles});
            end
        end
        bus.dmem_we = 1'b0;
    endtask

    task automatic test_pass();
        clear_plan();
        pl_we[10] = 1'b1; pl_addr[10] = TOHOST; pl_wd[10] = 1;
        run_plan("pass");
        total++;
        if ({bus.pass, bus.status, bus.cycles} !== {1'b1, 2'b01, CW'(10)}) begin
            bad++;
            $display("FAIL pass-const got=%h want=%h", {bus.pass, bus.status, bus.cycles}, {1'b1, 2'b01, CW'(10)});
        end
    endtask

    task automatic test_fail_code();
        clear_plan();
        pl_we[4] = 1'b1; pl_addr[4] = TOHOST + 4; pl_wd[4] = 1;
        pl_we[7] = 1'b1; pl_addr[7] = TOHOST;     pl_wd[7] = 32'h2A;
        run_plan("fail_code");
        total++;
        if ({bus.pass, bus.status, bus.exit_code} !== {1'b0, 2'b10, 32'h2A}) begin
            bad++;
            $display("FAIL fail-const got=%h want=%h", {bus.pass, bus.status, bus.exit_code}, {1'b0, 2'b10, 32'h2A});
        end
    endtask

    task automatic test_timeout();
        clear_plan();
        run_plan("timeout");
        total++;
        if ({bus.status, bus.cycles} !== {2'b11, CW'(MAXC - 1)}) begin
            bad++;
            $display("FAIL timeout-const got=%h want=%h", {bus.status, bus.cycles}, {2'b11, CW'(MAXC - 1)});
        end
        clear_plan();
        pl_we[MAXC-1] = 1'b1; pl_addr[MAXC-1] = TOHOST; pl_wd[MAXC-1] = 1;
        run_plan("hit_on_timeout");
        total++;
        if (bus.status !== 2'b01) begin
            bad++;
            $display("FAIL hit-beats-timeout status got=%b want=01", bus.status);
        end
    endtask

    task automatic test_hang();
        clear_plan();
        for (int k = 5; k < MAXC; k++) pl_pc[k] = 32'h40;
        run_plan("hang");
        total++;
`ifdef PC_HANG_DETECT_EN
        if ({bus.status, bus.exit_code} !== {2'b10, 32'hFFFF_FFFF}) begin
            bad++;
            $display("FAIL hang-const got=%h want=%h", {bus.status, bus.exit_code}, {2'b10, 32'hFFFF_FFFF});
        end
`else
        if (bus.status !== 2'b11) begin
            bad++;
            $display("FAIL hang-disabled status got=%b want=11", bus.status);
        end
`endif
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int stuck;
            clear_plan();
            stuck = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 150)) : MAXC;
            for (int k = 0; k < MAXC; k++) begin
                pl_we[k] = ($urandom_range(0, 15) == 0);
                case ($urandom_range(0, 2))
                    0:       pl_addr[k] = TOHOST;
                    1:       pl_addr[k] = TOHOST + 4;
                    default: pl_addr[k] = $urandom;
                endcase
                pl_wd[k] = ($urandom_range(0, 1) != 0) ? 32'd1 : DW'($urandom_range(0, 255));
                if (k >= stuck) pl_pc[k] = 32'h40;
            end
            run_plan($sformatf("random%0d", r));
        end
    endtask

    task automatic test_abort();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < RSTC + 50; i++) begin
            bus.pc = AW'(i * 4);
            @(posedge clk); #1;
        end
        total++;
        if ({bus.core_rst_n, bus.cycles} !== {1'b1, CW'(50)}) begin
            bad++;
            $display("FAIL abort-prerun got=%h want=%h", {bus.core_rst_n, bus.cycles}, {1'b1, CW'(50)});
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bus.core_rst_n, bus.done, bus.pass, bus.status, bus.exit_code, bus.cycles} !== '0) begin
            bad++;
            $display("FAIL abort-async got=%h want=0",
                     {bus.core_rst_n, bus.done, bus.pass, bus.status, bus.exit_code, bus.cycles});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_plan();
        pl_we[20] = 1'b1; pl_addr[20] = TOHOST; pl_wd[20] = 1;
        run_plan("after_abort");
        clear_plan();
        pl_we[3] = 1'b1; pl_addr[3] = TOHOST; pl_wd[3] = 32'h7;
        run_plan("back_to_back");
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_code();
        test_timeout();
        test_hang();
        test_random();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
